// File: rtl/uart_rx.sv
// 8N1 UART receiver with 3-sample majority voting per bit.
// Hands each good byte to a downstream write FIFO; a byte dropped on a full FIFO sets a sticky overflow flag.
module uart_rx #(
    parameter int BAUD_END = 433,
    parameter int MID      = BAUD_END / 2
) (
    input  logic       sclk,
    input  logic       reset,
    input  logic       RS232_rx,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic       frame_err,
    output logic       overflow,
    input  logic       wfifo_full,
    output logic       wfifo_wr_en,
    output logic [7:0] wfifo_wr_data
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } state_t;

    localparam logic [8:0] END_C = 9'(BAUD_END);
    localparam logic [8:0] LO_C  = 9'(MID - 1);
    localparam logic [8:0] MID_C = 9'(MID);
    localparam logic [8:0] DEC_C = 9'(MID + 1);

    state_t      state_q;
    logic        sync1_q;
    logic        rx_s_q;
    logic        rx_prev_q;
    logic [8:0]  baud_cnt_q;
    logic [2:0]  bit_cnt_q;
    logic [7:0]  shift_q;
    logic        smp0_q;
    logic        smp1_q;
    logic [7:0]  rx_data_q;
    logic        rx_done_q;
    logic        frame_err_q;
    logic        wr_en_q;
    logic        overflow_q;

    logic        wrap_d;
    logic        dec_d;
    logic        maj_d;
    logic        counting_d;

    always_comb begin
        wrap_d     = (baud_cnt_q == END_C);
        dec_d      = (baud_cnt_q == DEC_C);
        maj_d      = (smp0_q & smp1_q) | (smp0_q & rx_s_q) | (smp1_q & rx_s_q);
        counting_d = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    end

    always_ff @(posedge sclk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            rx_prev_q   <= 1'b1;
            baud_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            smp0_q      <= 1'b1;
            smp1_q      <= 1'b1;
            rx_data_q   <= '0;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_en_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            sync1_q     <= RS232_rx;
            rx_s_q      <= sync1_q;
            rx_prev_q   <= rx_s_q;
            rx_done_q   <= 1'b0;
            frame_err_q <= 1'b0;
            wr_en_q     <= 1'b0;

            if (counting_d) begin
                baud_cnt_q <= wrap_d ? 9'd0 : baud_cnt_q + 9'd1;
                if (baud_cnt_q == LO_C)  smp0_q <= rx_s_q;
                if (baud_cnt_q == MID_C) smp1_q <= rx_s_q;
            end

            case (state_q)
                IDLE: begin
                    baud_cnt_q <= '0;
                    if (rx_prev_q && !rx_s_q) begin
                        state_q   <= START;
                        bit_cnt_q <= '0;
                    end
                end
                START: begin
                    if (dec_d && maj_d) begin
                        state_q    <= IDLE;
                        baud_cnt_q <= '0;
                    end else if (wrap_d) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (dec_d) shift_q[bit_cnt_q] <= maj_d;
                    if (wrap_d) begin
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid stop bit so the next start edge is never missed.
                    if (dec_d) begin
                        baud_cnt_q <= '0;
                        if (maj_d) begin
                            state_q   <= IDLE;
                            rx_data_q <= shift_q;
                            rx_done_q <= 1'b1;
                            wr_en_q   <= !wfifo_full;
                            if (wfifo_full) overflow_q <= 1'b1;
                        end else begin
                            state_q     <= WAIT_IDLE;
                            frame_err_q <= 1'b1;
                        end
                    end
                end
                WAIT_IDLE: begin
                    baud_cnt_q <= '0;
                    if (rx_s_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rx_data       = rx_data_q;
    assign rx_done       = rx_done_q;
    assign frame_err     = frame_err_q;
    assign overflow      = overflow_q;
    assign wfifo_wr_en   = wr_en_q;
    assign wfifo_wr_data = rx_data_q;

endmodule
